// File: rtl/scan_sel_gen.sv
// scan_sel_gen: select-code generator feeding a 3-to-8 one-hot decoder.
// The code advances either on a prescaler tick (auto scan) or on a
// synchronised push-button edge (single step) and wraps after last_sel.

module scan_sel_gen #(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       step_btn,
    input  logic [2:0] last_sel,
    output logic [2:0] sel,
    output logic       adv,
    output logic       wrap
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             adv_q, adv_d;
    logic             wrap_q, wrap_d;

    logic             step_pulse;
    logic             tick;
    logic             adv_req;

    // Next-state logic: button synchroniser, prescaler and select advance.
    always_comb begin
        s1_d   = step_btn;
        s2_d   = s1_q;
        s3_d   = s2_q;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        adv_d  = 1'b0;
        wrap_d = 1'b0;

        step_pulse = s2_q & ~s3_q;
        tick       = (cnt_q == TERM);
        adv_req    = en & ((~mode & tick) | (mode & step_pulse));

        // Prescaler parks at zero in single-step mode so auto scan restarts
        // a full period after switching back; en=0 freezes it entirely.
        if (en) begin
            if (mode) begin
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The >= compare also recovers when last_sel drops below sel.
        if (adv_req) begin
            adv_d = 1'b1;
            if (sel_q >= last_sel) begin
                sel_d  = 3'd0;
                wrap_d = 1'b1;
            end else begin
                sel_d  = sel_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            cnt_q  <= '0;
            sel_q  <= 3'd0;
            adv_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            adv_q  <= adv_d;
            wrap_q <= wrap_d;
        end
    end

    assign sel  = sel_q;
    assign adv  = adv_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen: directed bench for scan_sel_gen with DIV=4 and DIV=1
// instances sharing the same input stimulus.

module tb_scan_sel_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       step_btn;
    logic [2:0] last_sel;
    logic [2:0] sel4, sel1;
    logic       adv4, adv1;
    logic       wrap4, wrap1;

    int n_checks = 0;
    int n_errors = 0;

    scan_sel_gen #(.DIV(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_btn(step_btn),
        .last_sel(last_sel), .sel(sel4), .adv(adv4), .wrap(wrap4)
    );

    scan_sel_gen #(.DIV(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_btn(step_btn),
        .last_sel(last_sel), .sel(sel1), .adv(adv1), .wrap(wrap1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare the DIV=4 instance outputs against expected values.
    task automatic check4(input string tag, input logic [2:0] e_sel,
                          input logic e_adv, input logic e_wrap);
        n_checks++;
        assert (sel4 === e_sel) else begin
            n_errors++;
            $error("[TB] FAIL %s.sel: observed %0d expected %0d", tag, sel4, e_sel);
        end
        n_checks++;
        assert (adv4 === e_adv) else begin
            n_errors++;
            $error("[TB] FAIL %s.adv: observed %0b expected %0b", tag, adv4, e_adv);
        end
        n_checks++;
        assert (wrap4 === e_wrap) else begin
            n_errors++;
            $error("[TB] FAIL %s.wrap: observed %0b expected %0b", tag, wrap4, e_wrap);
        end
    endtask

    // Compare the DIV=1 instance outputs against expected values.
    task automatic check1(input string tag, input logic [2:0] e_sel,
                          input logic e_adv, input logic e_wrap);
        n_checks++;
        assert (sel1 === e_sel) else begin
            n_errors++;
            $error("[TB] FAIL %s.sel: observed %0d expected %0d", tag, sel1, e_sel);
        end
        n_checks++;
        assert (adv1 === e_adv) else begin
            n_errors++;
            $error("[TB] FAIL %s.adv: observed %0b expected %0b", tag, adv1, e_adv);
        end
        n_checks++;
        assert (wrap1 === e_wrap) else begin
            n_errors++;
            $error("[TB] FAIL %s.wrap: observed %0b expected %0b", tag, wrap1, e_wrap);
        end
    endtask

    // Directed sequence; inputs change and outputs are sampled on falling edges.
    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        step_btn = 1'b0;
        last_sel = 3'd7;

        // Reset state.
        cyc(2);
        check4("reset", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;

        // Auto scan, last_sel=7: first advance on the 4th edge after release.
        cyc(3);
        check4("auto_pre", 3'd0, 1'b0, 1'b0);
        cyc(1);
        check4("auto_first", 3'd1, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            cyc(1);
            check4("auto_gap", 3'(i - 1), 1'b0, 1'b0);
            cyc(3);
            check4("auto_step", 3'(i % 8), 1'b1, (i == 8));
        end

        // Continue to sel=5, then hit reset between clock edges.
        for (int i = 1; i <= 5; i++) begin
            cyc(4);
            check4("auto_to5", 3'(i), 1'b1, 1'b0);
        end
        #2 rst = 1'b1;
        #1 check4("async_rst", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(3);
        check4("post_rst_pre", 3'd0, 1'b0, 1'b0);
        cyc(1);
        check4("post_rst_adv", 3'd1, 1'b1, 1'b0);

        // Single-step mode: held button gives one advance two edges after sampling.
        mode     = 1'b1;
        step_btn = 1'b1;
        cyc(1);
        check4("btn_k", 3'd1, 1'b0, 1'b0);
        cyc(1);
        check4("btn_k1", 3'd1, 1'b0, 1'b0);
        cyc(1);
        check4("btn_k2", 3'd2, 1'b1, 1'b0);
        cyc(18);
        check4("btn_held", 3'd2, 1'b0, 1'b0);
        step_btn = 1'b0;
        cyc(4);
        step_btn = 1'b1;
        cyc(3);
        check4("btn_second", 3'd3, 1'b1, 1'b0);
        step_btn = 1'b0;
        cyc(4);
        step_btn = 1'b1;
        cyc(3);
        check4("btn_to4", 3'd4, 1'b1, 1'b0);
        step_btn = 1'b0;
        cyc(4);

        // en low: press is discarded, not queued.
        en       = 1'b0;
        step_btn = 1'b1;
        cyc(3);
        check4("en_off_press", 3'd4, 1'b0, 1'b0);
        step_btn = 1'b0;
        cyc(7);
        check4("en_off_hold", 3'd4, 1'b0, 1'b0);
        en = 1'b1;
        cyc(2);
        check4("en_on_noqueue", 3'd4, 1'b0, 1'b0);
        step_btn = 1'b1;
        cyc(3);
        check4("en_on_press", 3'd5, 1'b1, 1'b0);
        step_btn = 1'b0;
        cyc(4);

        // Back to auto, reach sel=6, then lower last_sel to 3.
        mode = 1'b0;
        cyc(3);
        check4("auto_resume_pre", 3'd5, 1'b0, 1'b0);
        cyc(1);
        check4("auto_to6", 3'd6, 1'b1, 1'b0);
        last_sel = 3'd3;
        cyc(4);
        check4("lower_wrap", 3'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc(4);
            check4("lower_seq", 3'(i % 4), 1'b1, (i == 4));
        end

        // DIV=1 instance: last_sel=2 cycles every clock.
        rst = 1'b1;
        cyc(1);
        check1("div1_reset", 3'd0, 1'b0, 1'b0);
        rst      = 1'b0;
        last_sel = 3'd2;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            check1("div1_seq", 3'(i % 3), 1'b1, ((i % 3) == 0));
        end

        // last_sel=0: sel pinned at 0, every advance pulses adv and wrap.
        last_sel = 3'd0;
        cyc(1);
        check1("ls0_first", 3'd0, 1'b1, 1'b1);
        cyc(1);
        check1("ls0_second", 3'd0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Upstream driver for the 3-to-8 one-hot decoder.
- Produces the 3-bit select code that walks the decoder outputs across digit/LED enables.
- Two modes: auto-scan from a parameterised prescaler, or single-step from a raw push-button.
- The wrap point is programmable, so only the first last_sel+1 decoder outputs are visited.

Parameters:
- DIV, 4, prescaler terminal count: clock cycles per auto advance; legal range 1..2^16.
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- en  in  1  1 = block runs; 0 = sel, prescaler and outputs frozen.
- mode  in  1  0 = auto scan, 1 = single-step.
- step_btn  in  1  raw asynchronous push-button, active-high.
- last_sel  in  3  highest select value visited before wrapping to 0.
- sel  out  3  registered select code, drives decoder input.
- adv  out  1  registered one-cycle pulse, high in the cycle sel holds a newly advanced value.
- wrap  out  1  registered one-cycle pulse, high in the cycle sel became 0 via wrap.

Behaviour:
- Reset (async, any time, mid-scan included):
  - sel=0, adv=0, wrap=0, prescaler cnt=0.
  - Button synchroniser flops s1, s2, s3 all 0.
  - After release, first action occurs on the first qualifying clock edge; no stale pulse survives.
- Button path:
  - s1<=step_btn, s2<=s1, s3<=s2 every cycle (never gated by en).
  - step_pulse = s2 & ~s3, combinational.
  - Button high sampled at edge k gives step_pulse high between edges k+1 and k+2; sel updates at edge k+2.
  - A held button produces exactly one pulse; bounces shorter than one clock may be missed (no debounce filter in this block).
- Prescaler:
  - Counts only when en=1 and mode=0.
  - tick = (cnt == DIV-1); on tick cnt<=0, else cnt<=cnt+1.
  - DIV=1 gives a tick every enabled cycle.
  - While mode=1, cnt is held at 0, so the first auto tick after returning to mode 0 comes DIV cycles later.
  - en=0 holds cnt and does not clear it.
- Advance request:
  - adv_req = en & ((mode==0 & tick) | (mode==1 & step_pulse)).
  - mode is sampled in the same cycle. A step_pulse while mode=0, or a tick while mode=1, is discarded.
  - step_pulse while en=0 is discarded, not queued.
- Advance action at clock edge with adv_req=1:
  - If sel >= last_sel: sel<=0, wrap<=1.
  - Else: sel<=sel+1, wrap<=0.
  - In both cases adv<=1.
- Without adv_req: sel holds, adv<=0, wrap<=0.
- Unsigned 3-bit compare; no overflow possible since sel <= 7.
- last_sel = 7 walks all eight codes 0..7.
- last_sel = 0 keeps sel at 0; every advance pulses adv and wrap together.
- last_sel lowered below current sel: the next advance goes to 0 with wrap=1 (>= rule); no out-of-range value is ever held past one advance.
- last_sel is sampled only on advance edges and may change at any time.
- en deassert mid-scan: sel frozen at its current value, adv and wrap drop to 0 next edge; resumes from the same sel and cnt.
- Auto-mode timing: adv pulses are exactly DIV cycles apart; sel sequence 0,1,..,last_sel,0,...

Test Plan:
- DIV=4, rst pulse mid-run with sel=5 -> sel, adv, wrap go 0 asynchronously before the next clk edge; cnt restarts at 0.
- DIV=4, en=1, mode=0, last_sel=7 -> first adv 4 cycles after reset release; sel goes 1,2,...,7,0 every 4 cycles; wrap high exactly with sel=0 once per 32 cycles.
- mode=1, step_btn high for 20 cycles starting before edge k -> sel 0->1 at edge k+2, single adv pulse, no further change while held; second press -> sel=2.
- last_sel=2, auto, DIV=1 -> sel cycles 0,1,2,0,1,2 every clock; wrap high every third cycle.
- sel=6 in auto, then last_sel changed to 3 -> next advance sel=0 with wrap=1, then 1,2,3,0.
- en dropped at sel=4 for 10 cycles, step_btn pressed during that window in mode=1 -> sel stays 4, no adv; after en=1 the next press -> sel=5.
